// File: rtl/pb_event_pkg.sv
// rtl/pb_event_pkg.sv - shared state encoding and default timing constants for the push-button decoder
package pb_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } pb_fsm_e;

    localparam int DEF_PRESCALE     = 50000;
    localparam int DEF_LONG_TICKS   = 800;
    localparam int DEF_DCLICK_TICKS = 250;
    localparam int DEF_REPEAT_TICKS = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pb_event_if.sv
// rtl/pb_event_if.sv - button strobe / gesture event bundle between a debouncer side and the decoder side
interface pb_event_if;
    logic pb_state;
    logic pb_down;
    logic pb_up;
    logic ev_short;
    logic ev_double;
    logic ev_long;
    logic ev_repeat;
    logic busy;

    modport master (
        output pb_state, pb_down, pb_up,
        input  ev_short, ev_double, ev_long, ev_repeat, busy
    );

    modport slave (
        input  pb_state, pb_down, pb_up,
        output ev_short, ev_double, ev_long, ev_repeat, busy
    );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider emitting a one-cycle TICK every PRESCALE clocks
module tick_prescaler
    import pb_event_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);
    localparam int            CW   = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign TICK = (r_cnt == LAST);
endmodule

// File: rtl/pb_event_decoder.sv
// rtl/pb_event_decoder.sv - turns debounced press/release strobes into short, double, long and repeat events
module pb_event_decoder
    import pb_event_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic CLK,
    input  logic RST,
    input  logic PB_state,
    input  logic PB_down,
    input  logic PB_up,
    output logic EV_SHORT,
    output logic EV_DOUBLE,
    output logic EV_LONG,
    output logic EV_REPEAT,
    output logic BUSY
);
    localparam int            TMAX        = max3(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS);
    localparam int            TW          = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_TICKS - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_TICKS - 1);
    localparam logic [TW-1:0] TIMER_SAT   = '1;

    logic          w_tick;
    pb_fsm_e       r_state;
    pb_fsm_e       w_state_next;
    logic [TW-1:0] r_timer;
    logic          w_timer_clr;
    logic          w_down;
    logic          w_long_due;
    logic          w_dclick_due;
    logic          w_repeat_due;
    logic          r_ev_short, r_ev_double, r_ev_long, r_ev_repeat;
    logic          w_ev_short, w_ev_double, w_ev_long, w_ev_repeat;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (w_tick)
    );

    // A press strobe arriving together with a release strobe is dropped.
    assign w_down       = PB_down & ~PB_up;
    assign w_long_due   = w_tick && (r_timer == LONG_LAST);
    assign w_dclick_due = w_tick && (r_timer == DCLICK_LAST);
    assign w_repeat_due = w_tick && (r_timer == REPEAT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_ev_short  <= 1'b0;
            r_ev_double <= 1'b0;
            r_ev_long   <= 1'b0;
            r_ev_repeat <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ev_short  <= w_ev_short;
            r_ev_double <= w_ev_double;
            r_ev_long   <= w_ev_long;
            r_ev_repeat <= w_ev_repeat;
        end
    end

    // Release/press strobes win over same-cycle timeouts; a level that
    // disagrees with the state means a lost strobe, so resynchronise to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_timer_clr  = 1'b0;
        w_ev_short   = 1'b0;
        w_ev_double  = 1'b0;
        w_ev_long    = 1'b0;
        w_ev_repeat  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_down) w_state_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (PB_up) begin
                    w_state_next = ST_WAIT_SECOND;
                end else if (!PB_state) begin
                    w_state_next = ST_IDLE;
                end else if (w_long_due) begin
                    w_state_next = ST_LONG_HELD;
                    w_ev_long    = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (PB_up || !PB_state) begin
                    w_state_next = ST_IDLE;
                end else if (w_repeat_due) begin
                    w_ev_repeat = 1'b1;
                    w_timer_clr = 1'b1;
                end
            end
            ST_WAIT_SECOND: begin
                if (w_down) begin
                    w_state_next = ST_SECOND_PRESSED;
                end else if (PB_state) begin
                    w_state_next = ST_IDLE;
                end else if (w_dclick_due) begin
                    w_state_next = ST_IDLE;
                    w_ev_short   = 1'b1;
                end
            end
            ST_SECOND_PRESSED: begin
                if (PB_up) begin
                    w_state_next = ST_IDLE;
                    w_ev_double  = 1'b1;
                end else if (!PB_state) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer <= '0;
        end else if ((w_state_next != r_state) || w_timer_clr) begin
            r_timer <= '0;
        end else if (w_tick && (r_timer != TIMER_SAT)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign EV_SHORT  = r_ev_short;
    assign EV_DOUBLE = r_ev_double;
    assign EV_LONG   = r_ev_long;
    assign EV_REPEAT = r_ev_repeat;
    assign BUSY      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_pb_event_decoder.sv
// tb/tb_pb_event_decoder.sv - scoreboard bench for pb_event_decoder with a gesture-level reference model
module tb_pb_event_decoder;
    localparam int P  = 4;
    localparam int LT = 10;
    localparam int DT = 5;
    localparam int RT = 3;

    localparam int K_SHORT  = 0;
    localparam int K_DOUBLE = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    typedef struct {
        int cyc;
        bit busy;
        bit zero_ev;
    } st_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pb_event_if bus ();

    always #5 CLK = ~CLK;

    pb_event_decoder #(
        .PRESCALE     (P),
        .LONG_TICKS   (LT),
        .DCLICK_TICKS (DT),
        .REPEAT_TICKS (RT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PB_state  (bus.pb_state),
        .PB_down   (bus.pb_down),
        .PB_up     (bus.pb_up),
        .EV_SHORT  (bus.ev_short),
        .EV_DOUBLE (bus.ev_double),
        .EV_LONG   (bus.ev_long),
        .EV_REPEAT (bus.ev_repeat),
        .BUSY      (bus.busy)
    );

    ev_t sb[$];
    st_t stq[$];
    int  pa[$];
    int  pb[$];
    int  cyc    = 0;
    int  r_cyc  = 0;
    int  checks = 0;
    int  errors = 0;
    bit  done   = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_SHORT:  return "SHORT";
            K_DOUBLE: return "DOUBLE";
            K_LONG:   return "LONG";
            default:  return "REPEAT";
        endcase
    endfunction

    // Ticks land on the last cycle of each PRESCALE-long window after reset release.
    function automatic bit is_tick(input int c);
        return (c >= r_cyc) && (((c - r_cyc) % P) == P - 1);
    endfunction

    function automatic int nth_tick(input int c, input int n);
        int k;
        int seen;
        k    = c;
        seen = 0;
        while (seen < n) begin
            k++;
            if (is_tick(k)) seen++;
        end
        return k;
    endfunction

    function automatic void expect_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    function automatic void expect_st(input int c, input bit busy, input bit zero_ev);
        st_t s;
        s.cyc     = c;
        s.busy    = busy;
        s.zero_ev = zero_ev;
        stq.push_back(s);
    endfunction

    function automatic void add_press(input int a, input int b);
        pa.push_back(a);
        pb.push_back(b);
    endfunction

    // Gesture-level model: each press/release pair is classified by counting ticks.
    task automatic plan_model();
        bit pending;
        int s5;
        int a, b, t10, t;
        pending = 1'b0;
        s5      = 0;
        for (int i = 0; i < pa.size(); i++) begin
            a = pa[i];
            b = pb[i];
            if (pending && a <= s5) begin
                expect_ev(K_DOUBLE, b + 1);
                pending = 1'b0;
            end else begin
                if (pending) begin
                    expect_ev(K_SHORT, s5 + 1);
                    pending = 1'b0;
                end
                t10 = nth_tick(a, LT);
                if (b <= t10) begin
                    pending = 1'b1;
                    s5      = nth_tick(b, DT);
                end else begin
                    expect_ev(K_LONG, t10 + 1);
                    t = nth_tick(t10, RT);
                    while (t < b) begin
                        expect_ev(K_REPEAT, t + 1);
                        t = nth_tick(t, RT);
                    end
                end
            end
        end
        if (pending) expect_ev(K_SHORT, s5 + 1);
    endtask

    task automatic run_presses();
        int i;
        int last;
        i    = 0;
        last = pb[pb.size() - 1] + 40;
        while (cyc < last) begin
            @(posedge CLK);
            #1;
            if (i < pa.size()) begin
                bus.pb_down  = (cyc == pa[i]);
                bus.pb_up    = (cyc == pb[i]);
                bus.pb_state = (cyc >= pa[i]) && (cyc < pb[i]);
                if (cyc == pb[i]) i++;
            end else begin
                bus.pb_down  = 1'b0;
                bus.pb_up    = 1'b0;
                bus.pb_state = 1'b0;
            end
        end
    endtask

    task automatic add_random(input int count);
        int t, a, b;
        t = (pb.size() != 0) ? pb[pb.size() - 1] : cyc + 1;
        for (int n = 0; n < count; n++) begin
            a = t + int'($urandom_range(35, 1));
            b = a + int'($urandom_range(80, 1));
            add_press(a, b);
            t = b;
        end
    endtask

    initial begin
        int a, b, c, t, rc;
        bus.pb_state = 1'b0;
        bus.pb_down  = 1'b0;
        bus.pb_up    = 1'b0;
        expect_st(2, 1'b0, 1'b1);
        expect_st(3, 1'b0, 1'b1);
        repeat (4) @(posedge CLK);
        #1;
        RST   = 1'b0;
        r_cyc = cyc;

        a = cyc + 2;
        b = nth_tick(a, 3);
        add_press(a, b);
        expect_st(b + 1, 1'b1, 1'b0);

        a = b + 40;
        b = nth_tick(a, 2);
        add_press(a, b);
        c = nth_tick(b, 2);
        add_press(c, c + 3);

        a = c + 13;
        b = nth_tick(a, 19) + 2;
        add_press(a, b);

        a = b + 10;
        b = nth_tick(a, LT);
        add_press(a, b);
        expect_st(b + 1, 1'b1, 1'b0);

        a = b + 40;
        b = a + 5;
        add_press(a, b);
        c = nth_tick(b, DT);
        add_press(c, c + 4);

        add_random(20);
        plan_model();
        run_presses();

        pa.delete();
        pb.delete();
        a  = cyc + 2;
        t  = nth_tick(a, LT);
        expect_ev(K_LONG, t + 1);
        rc = t + 2;
        expect_st(rc + 1, 1'b0, 1'b1);
        while (cyc < rc) begin
            @(posedge CLK);
            #1;
            bus.pb_down  = (cyc == a);
            bus.pb_state = (cyc >= a);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        bus.pb_down  = 1'b0;
        bus.pb_state = 1'b0;
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        r_cyc = cyc;
        repeat (40) @(posedge CLK);
        #1;

        a = cyc + 2;
        expect_st(a + 1, 1'b1, 1'b0);
        expect_st(a + 4, 1'b0, 1'b0);
        while (cyc < a + 43) begin
            @(posedge CLK);
            #1;
            bus.pb_down  = (cyc == a);
            bus.pb_up    = 1'b0;
            bus.pb_state = (cyc >= a) && (cyc < a + 3);
        end

        add_random(4);
        plan_model();
        run_presses();

        done = 1'b1;
        repeat (5) @(posedge CLK);
        $display("FAIL finish_watchdog: monitor did not end the run, got no summary, required summary");
        $fatal(1);
    end

    initial begin
        #1000000;
        $display("FAIL time_limit: got %0d cycles without finish, required finish", cyc);
        $fatal(1);
    end

    always @(negedge CLK) begin
        int  k;
        int  n;
        bit  eb;
        ev_t e;
        st_t s;
        n = int'(bus.ev_short) + int'(bus.ev_double) + int'(bus.ev_long) + int'(bus.ev_repeat);
        if (n != 0) begin
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL ev_exclusive cycle %0d: got %0d events high, required 1", cyc, n);
            end
            k = bus.ev_short ? K_SHORT : bus.ev_double ? K_DOUBLE : bus.ev_long ? K_LONG : K_REPEAT;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cycle %0d: got %s, required none", cyc, kname(k));
            end else begin
                e = sb.pop_front();
                if (e.kind != k || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                             kname(k), cyc, kname(e.kind), e.cyc);
                end
                checks++;
                eb = (k == K_LONG) || (k == K_REPEAT);
                if (bus.busy !== eb) begin
                    errors++;
                    $display("FAIL busy_at_event cycle %0d: got %0b, required %0b", cyc, bus.busy, eb);
                end
            end
        end
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing, required %s at cycle %0d", kname(e.kind), e.cyc);
        end
        while (stq.size() != 0 && stq[0].cyc <= cyc) begin
            s = stq.pop_front();
            checks++;
            if (s.cyc != cyc || bus.busy !== s.busy || (s.zero_ev && n != 0)) begin
                errors++;
                $display("FAIL status cycle %0d: got busy=%0b events=%0d, required busy=%0b at cycle %0d%s",
                         cyc, bus.busy, n, s.busy, s.cyc, s.zero_ev ? " events=0" : "");
            end
        end
        if (done) begin
            checks++;
            if (sb.size() != 0 || stq.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d events and %0d status checks pending, required 0", sb.size(), stq.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end
endmodule
